// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver: JK control codes,
// FSM state encoding and the per-bit excitation function.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    APPLY  = 2'd2,
    VERIFY = 2'd3
  } state_t;

  // Returns {J,K} that moves one flop from cur to nxt; dc fills the don't-care term.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt, input logic dc);
    logic [1:0] code;
    case ({cur, nxt})
      2'b00:   code = {1'b0, dc};
      2'b01:   code = {1'b1, dc};
      2'b10:   code = {dc, 1'b1};
      default: code = {dc, 1'b0};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Target handshake bundle: a source offers a desired state vector, the
// driver accepts it when ready.
interface jk_excitation_driver_if #(parameter int WIDTH = 4);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with a common enable. qbar is kept in its own
// register so it is a true flop output, reset to all ones.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [2*WIDTH-1:0] i_jk,
  output logic [WIDTH-1:0]   o_q,
  output logic [WIDTH-1:0]   o_qbar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qbar;

  // Each bit follows its JK code only while the bank is enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q    <= '0;
      r_qbar <= '1;
    end else if (i_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (i_jk[2*i +: 2])
          JK_RESET: begin
            r_q[i]    <= 1'b0;
            r_qbar[i] <= 1'b1;
          end
          JK_SET: begin
            r_q[i]    <= 1'b1;
            r_qbar[i] <= 1'b0;
          end
          JK_TOGGLE: begin
            r_q[i]    <= ~r_q[i];
            r_qbar[i] <= ~r_qbar[i];
          end
          default: begin
            r_q[i]    <= r_q[i];
            r_qbar[i] <= r_qbar[i];
          end
        endcase
      end
    end
  end

  assign o_q    = r_q;
  assign o_qbar = r_qbar;

endmodule

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: accepts a target state, derives J/K per bit from the
// current bank state, clocks the bank once and pulses done.
// Optional macro JK_MISMATCH_CHECK_EN adds a sticky err flag and an 8-bit
// saturating mismatch counter (r_mismatch_cnt) checked in VERIFY.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DC_POLICY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  jk_excitation_driver_if.slave      tgt,
  output logic [2*WIDTH-1:0]         jk,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           qbar,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] toggle_cnt,
  output logic                       err
);

  localparam int   CW = $clog2(WIDTH+1);
  localparam logic DC = (DC_POLICY != 0);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_bank_en;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_qbar;
  logic [WIDTH-1:0]   r_q_old;
  logic [2*WIDTH-1:0] r_jk;
  logic [2*WIDTH-1:0] w_jk_next;
  logic [CW-1:0]      w_pop;
  logic [CW-1:0]      r_toggle_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic plus handshake, busy, done and bank enable.
  always_comb begin
    w_next        = r_state;
    tgt.tgt_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    w_bank_en     = 1'b0;
    case (r_state)
      IDLE: begin
        tgt.tgt_ready = 1'b1;
        busy          = 1'b0;
        if (tgt.tgt_valid) w_next = LOAD;
      end
      LOAD:    w_next = APPLY;
      APPLY: begin
        w_bank_en = 1'b1;
        w_next    = VERIFY;
      end
      VERIFY: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = tgt.tgt_valid && tgt.tgt_ready;

  // Excitation for the incoming target against the present bank state.
  always_comb begin
    w_jk_next = '0;
    for (int i = 0; i < WIDTH; i++)
      w_jk_next[2*i +: 2] = jk_excite(w_q[i], tgt.tgt_data[i], DC);
  end

  // Register jk and the pre-transaction state at accept; jk then holds until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jk    <= '0;
      r_q_old <= '0;
    end else if (w_accept) begin
      r_jk    <= w_jk_next;
      r_q_old <= w_q;
    end
  end

  jk_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_bank_en),
    .i_jk    (r_jk),
    .o_q     (w_q),
    .o_qbar  (w_qbar)
  );

  // Count of bits that differ between the pre-transaction state and q.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      w_pop = w_pop + CW'(r_q_old[i] ^ w_q[i]);
  end

  // Keep the last transaction's toggle count after VERIFY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_toggle_cnt <= '0;
    else if (done) r_toggle_cnt <= w_pop;
  end

  assign toggle_cnt = done ? w_pop : r_toggle_cnt;
  assign jk         = r_jk;
  assign q          = w_q;
  assign qbar       = w_qbar;

`ifdef JK_MISMATCH_CHECK_EN
  logic [WIDTH-1:0] r_tgt;
  logic             r_err;
  logic [7:0]       r_mismatch_cnt;

  // Hold the accepted target for the VERIFY compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_tgt <= '0;
    else if (w_accept) r_tgt <= tgt.tgt_data;
  end

  // Sticky error and saturating mismatch count when q misses the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err          <= 1'b0;
      r_mismatch_cnt <= '0;
    end else if (done && (w_q != r_tgt)) begin
      r_err <= 1'b1;
      if (r_mismatch_cnt != 8'hFF) r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed self-checking bench for jk_excitation_driver: one DUT per
// don't-care policy, sharing clock and reset.
module tb_jk_excitation_driver;

  logic clk;
  logic rst_n;

  jk_excitation_driver_if #(.WIDTH(4)) if0 ();
  jk_excitation_driver_if #(.WIDTH(4)) if1 ();

  logic [7:0] jk0, jk1;
  logic [3:0] q0, q1, qbar0, qbar1;
  logic       busy0, busy1, done0, done1, err0, err1;
  logic [2:0] tc0, tc1;

  jk_excitation_driver #(.WIDTH(4), .DC_POLICY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt(if0.slave), .jk(jk0), .q(q0), .qbar(qbar0),
    .busy(busy0), .done(done0), .toggle_cnt(tc0), .err(err0)
  );

  jk_excitation_driver #(.WIDTH(4), .DC_POLICY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt(if1.slave), .jk(jk1), .q(q1), .qbar(qbar1),
    .busy(busy1), .done(done1), .toggle_cnt(tc1), .err(err1)
  );

  // Observation mux so one scenario task can address either DUT.
  logic       sel;
  logic [7:0] o_jk;
  logic [3:0] o_q, o_qbar;
  logic       o_busy, o_done, o_ready;
  logic [2:0] o_tc;
  assign o_jk    = sel ? jk1 : jk0;
  assign o_q     = sel ? q1 : q0;
  assign o_qbar  = sel ? qbar1 : qbar0;
  assign o_busy  = sel ? busy1 : busy0;
  assign o_done  = sel ? done1 : done0;
  assign o_ready = sel ? if1.tgt_ready : if0.tgt_ready;
  assign o_tc    = sel ? tc1 : tc0;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    if (sel) begin
      if1.tgt_valid = v;
      if1.tgt_data  = d;
    end else begin
      if0.tgt_valid = v;
      if0.tgt_data  = d;
    end
  endtask

  // Bench-side excitation table and popcount.
  function automatic logic [7:0] model_jk(input logic [3:0] cur, input logic [3:0] t, input logic dc);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (!cur[i] && !t[i])     r[2*i +: 2] = {1'b0, dc};
      else if (!cur[i] && t[i]) r[2*i +: 2] = {1'b1, dc};
      else if (cur[i] && !t[i]) r[2*i +: 2] = {dc, 1'b1};
      else                      r[2*i +: 2] = {dc, 1'b0};
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 1'b0;
    if0.tgt_valid = 1'b0; if0.tgt_data = '0;
    if1.tgt_valid = 1'b0; if1.tgt_data = '0;
    tick(); tick();
    checks++; if (q0 !== 4'b0000) begin errors++; $display("[TB] FAIL reset_q got %b expected 0000", q0); end
    checks++; if (qbar0 !== 4'b1111) begin errors++; $display("[TB] FAIL reset_qbar got %b expected 1111", qbar0); end
    checks++; if (jk0 !== 8'h00) begin errors++; $display("[TB] FAIL reset_jk got %b expected 00000000", jk0); end
    checks++; if (if0.tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", if0.tgt_ready); end
    checks++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_busy got %b%b expected 00", done0, busy0); end
    checks++; if (tc0 !== 3'd0 || err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc_err got %0d/%b expected 0/0", tc0, err0); end
    rst_n = 1'b1;
    tick();
  endtask

  // One full transaction with cycle-by-cycle checks.
  task automatic test_vector(input string name, input logic use_dc1, input logic [3:0] old_q,
                             input logic [3:0] target, input logic [7:0] exp_jk,
                             input logic [3:0] exp_q, input logic [2:0] exp_tc);
    sel = use_dc1;
    #0;
    drive(1'b1, target);
    #0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s idle_ready got %b expected 1", name, o_ready); end
    tick();
    drive(1'b0, target);
    checks++; if (o_ready !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("[TB] FAIL %s load_ready_busy got %b%b expected 01", name, o_ready, o_busy); end
    checks++; if (o_jk !== exp_jk) begin errors++; $display("[TB] FAIL %s jk got %b expected %b", name, o_jk, exp_jk); end
    checks++; if (o_q !== old_q) begin errors++; $display("[TB] FAIL %s load_q got %b expected %b", name, o_q, old_q); end
    tick();
    checks++; if (o_q !== old_q || o_done !== 1'b0) begin errors++; $display("[TB] FAIL %s apply_q_done got %b/%b expected %b/0", name, o_q, o_done, old_q); end
    tick();
    checks++; if (o_done !== 1'b1) begin errors++; $display("[TB] FAIL %s verify_done got %b expected 1", name, o_done); end
    checks++; if (o_q !== exp_q || o_qbar !== ~exp_q) begin errors++; $display("[TB] FAIL %s q_qbar got %b/%b expected %b/%b", name, o_q, o_qbar, exp_q, ~exp_q); end
    checks++; if (o_tc !== exp_tc) begin errors++; $display("[TB] FAIL %s toggle_cnt got %0d expected %0d", name, o_tc, exp_tc); end
    tick();
    checks++; if (o_done !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s post_done_ready got %b%b expected 01", name, o_done, o_ready); end
    checks++; if (o_jk !== exp_jk || o_tc !== exp_tc) begin errors++; $display("[TB] FAIL %s hold_jk_tc got %b/%0d expected %b/%0d", name, o_jk, o_tc, exp_jk, exp_tc); end
  endtask

  task automatic test_reset_idle();
    sel = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (q0 !== 4'b0000 || qbar0 !== 4'b1111) begin errors++; $display("[TB] FAIL idle_reset_q got %b/%b expected 0000/1111", q0, qbar0); end
    checks++; if (jk0 !== 8'h00 || tc0 !== 3'd0) begin errors++; $display("[TB] FAIL idle_reset_jk_tc got %b/%0d expected 00000000/0", jk0, tc0); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    drive(1'b1, 4'b1111);
    tick();
    checks++; if (if0.tgt_ready !== 1'b0 || jk0 !== 8'b10101010) begin errors++; $display("[TB] FAIL b2b_load1 got %b/%b expected 0/10101010", if0.tgt_ready, jk0); end
    tick();
    checks++; if (if0.tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_apply1_ready got %b expected 0", if0.tgt_ready); end
    tick();
    checks++; if (if0.tgt_ready !== 1'b0 || done0 !== 1'b1 || q0 !== 4'b1111) begin errors++; $display("[TB] FAIL b2b_verify1 got %b/%b/%b expected 0/1/1111", if0.tgt_ready, done0, q0); end
    drive(1'b1, 4'b0000);
    tick();
    checks++; if (if0.tgt_ready !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b/%b/%b expected 1/0/0", if0.tgt_ready, busy0, done0); end
    tick();
    drive(1'b0, 4'b0000);
    checks++; if (if0.tgt_ready !== 1'b0 || jk0 !== 8'b01010101) begin errors++; $display("[TB] FAIL b2b_load2 got %b/%b expected 0/01010101", if0.tgt_ready, jk0); end
    tick();
    tick();
    checks++; if (done0 !== 1'b1 || q0 !== 4'b0000 || tc0 !== 3'd4) begin errors++; $display("[TB] FAIL b2b_verify2 got %b/%b/%0d expected 1/0000/4", done0, q0, tc0); end
    tick();
  endtask

  task automatic test_reset_mid_apply();
    sel = 1'b0;
    drive(1'b1, 4'b0110);
    tick();
    drive(1'b0, 4'b0110);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (q0 !== 4'b0000 || busy0 !== 1'b0 || if0.tgt_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_state got %b/%b/%b expected 0000/0/1", q0, busy0, if0.tgt_ready); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (done0 !== 1'b0 || q0 !== 4'b0000) begin errors++; $display("[TB] FAIL abort_no_done got %b/%b expected 0/0000", done0, q0); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] mq;
    logic [3:0] t;
    sel = 1'b0;
    mq  = 4'b0000;
    for (int n = 0; n < 20; n++) begin
      t = 4'($urandom_range(0, 15));
      drive(1'b1, t);
      tick();
      drive(1'b0, t);
      checks++; if (jk0 !== model_jk(mq, t, 1'b0)) begin errors++; $display("[TB] FAIL rand_jk got %b expected %b", jk0, model_jk(mq, t, 1'b0)); end
      tick();
      tick();
      checks++; if (q0 !== t || done0 !== 1'b1 || tc0 !== 3'($countones(mq ^ t))) begin errors++; $display("[TB] FAIL rand_result got %b/%b/%0d expected %b/1/%0d", q0, done0, tc0, t, $countones(mq ^ t)); end
      tick();
      mq = t;
    end
    checks++; if (err0 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("[TB] FAIL err_flag got %b%b expected 00", err0, err1); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_vector("dc0_0000_1010", 1'b0, 4'b0000, 4'b1010, 8'b10001000, 4'b1010, 3'd2);
    test_vector("dc0_1010_0110", 1'b0, 4'b1010, 4'b0110, 8'b01100000, 4'b0110, 3'd2);
    test_vector("dc0_same", 1'b0, 4'b0110, 4'b0110, 8'b00000000, 4'b0110, 3'd0);
    test_reset_idle();
    test_vector("dc1_0000_1010", 1'b1, 4'b0000, 4'b1010, 8'b11011101, 4'b1010, 3'd2);
    test_vector("dc1_same", 1'b1, 4'b1010, 4'b1010, 8'b10011001, 4'b1010, 3'd0);
    test_back_to_back();
    test_reset_mid_apply();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
